// File: rtl/f_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : f_pc_unit
// Summary  : Fetch-stage PC generator and F/D PC pipeline register.
//            Resolves D-stage branches/jumps internally, keeps the
//            architectural delay slot, supports stall and external redirect.
//            Optional fetch address-error detection under macro PC_ADEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module f_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Req,
    input  logic [31:0] Req_PC,
    input  logic [3:0]  D_SelPCsrc,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Addr26,
    input  logic [31:0] D_RD1,
    input  logic [31:0] D_RD2,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic        D_valid,
    output logic        D_Taken,
    output logic        F_AdEL,
    output logic        D_AdEL
);

    // Transfer-type encodings of D_SelPCsrc
    localparam logic [3:0] c_sel_beq  = 4'd1;
    localparam logic [3:0] c_sel_bne  = 4'd2;
    localparam logic [3:0] c_sel_blez = 4'd3;
    localparam logic [3:0] c_sel_bgtz = 4'd4;
    localparam logic [3:0] c_sel_bltz = 4'd5;
    localparam logic [3:0] c_sel_bgez = 4'd6;
    localparam logic [3:0] c_sel_j    = 4'd7;
    localparam logic [3:0] c_sel_jr   = 4'd8;

    logic [31:0] r_f_pc;
    logic [31:0] r_d_pc;
    logic        r_d_valid;
    logic        r_d_adel;

    logic        w_rs_neg;
    logic        w_rs_zero;
    logic        w_cond;
    logic [31:0] w_target;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_f_adel;

    // Elaboration-time sanity check of the legal fetch window
    if (PC_LO > PC_HI) begin : g_range_check
        $error("f_pc_unit: PC_LO must not exceed PC_HI");
    end

    assign w_rs_neg    = D_RD1[31];
    assign w_rs_zero   = (D_RD1 == 32'd0);
    assign w_seq_pc    = r_f_pc + 32'd4;
    assign w_br_target = r_d_pc + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
    assign w_j_target  = {r_d_pc[31:28], D_Addr26, 2'b00};

    // Condition evaluation and target selection for the D-stage transfer
    always_comb begin
        w_cond   = 1'b0;
        w_target = w_br_target;
        case (D_SelPCsrc)
            c_sel_beq:  w_cond = (D_RD1 == D_RD2);
            c_sel_bne:  w_cond = (D_RD1 != D_RD2);
            c_sel_blez: w_cond = w_rs_neg | w_rs_zero;
            c_sel_bgtz: w_cond = ~w_rs_neg & ~w_rs_zero;
            c_sel_bltz: w_cond = w_rs_neg;
            c_sel_bgez: w_cond = ~w_rs_neg;
            c_sel_j: begin
                w_cond   = 1'b1;
                w_target = w_j_target;
            end
            c_sel_jr: begin
                w_cond   = 1'b1;
                w_target = D_RD1;
            end
            default:    w_cond = 1'b0;
        endcase
    end

    assign w_taken   = r_d_valid & w_cond;
    assign w_next_pc = w_taken ? w_target : w_seq_pc;

`ifdef PC_ADEL_EN
    assign w_f_adel = (r_f_pc[1:0] != 2'b00) | (r_f_pc < PC_LO) | (r_f_pc > PC_HI);
`else
    assign w_f_adel = 1'b0;
`endif

    // F/D register update: reset > redirect > stall > normal advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc    <= RESET_PC;
            r_d_pc    <= 32'd0;
            r_d_valid <= 1'b0;
            r_d_adel  <= 1'b0;
        end else if (Req) begin
            r_f_pc    <= Req_PC;
            r_d_pc    <= 32'd0;
            r_d_valid <= 1'b0;
            r_d_adel  <= 1'b0;
        end else if (!Stall) begin
            r_f_pc    <= w_next_pc;
            r_d_pc    <= r_f_pc;
            r_d_valid <= 1'b1;
            r_d_adel  <= w_f_adel;
        end
    end

    assign F_PC    = r_f_pc;
    assign D_PC    = r_d_pc;
    assign D_valid = r_d_valid;
    assign D_Taken = w_taken;
    assign F_AdEL  = w_f_adel;
    assign D_AdEL  = r_d_adel;

endmodule
`default_nettype wire

// File: tb/tb_f_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_pc_unit
// Summary  : Directed self-checking bench for f_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_pc_unit;

`ifdef PC_ADEL_EN
    localparam logic c_adel = 1'b1;
`else
    localparam logic c_adel = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Req;
    logic [31:0] Req_PC;
    logic [3:0]  D_SelPCsrc;
    logic [15:0] D_Imm16;
    logic [25:0] D_Addr26;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic        D_valid;
    logic        D_Taken;
    logic        F_AdEL;
    logic        D_AdEL;

    int checks = 0;
    int errors = 0;

    f_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .Req        (Req),
        .Req_PC     (Req_PC),
        .D_SelPCsrc (D_SelPCsrc),
        .D_Imm16    (D_Imm16),
        .D_Addr26   (D_Addr26),
        .D_RD1      (D_RD1),
        .D_RD2      (D_RD2),
        .F_PC       (F_PC),
        .D_PC       (D_PC),
        .D_valid    (D_valid),
        .D_Taken    (D_Taken),
        .F_AdEL     (F_AdEL),
        .D_AdEL     (D_AdEL)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] sel, input logic [15:0] imm,
                         input logic [31:0] rd1, input logic [31:0] rd2);
        D_SelPCsrc = sel;
        D_Imm16    = imm;
        D_RD1      = rd1;
        D_RD2      = rd2;
        #1;
    endtask

    // Directed sequence
    initial begin
        reset = 1'b1; Stall = 1'b0; Req = 1'b0; Req_PC = 32'd0;
        D_SelPCsrc = 4'd0; D_Imm16 = 16'd0; D_Addr26 = 26'd0;
        D_RD1 = 32'd0; D_RD2 = 32'd0;

        // Reset held two cycles
        step(); step();
        chk("rst_fpc",    F_PC, 32'h3000);
        chk("rst_dvalid", {31'd0, D_valid}, 32'd0);
        chk("rst_dpc",    D_PC, 32'h0);
        chk("rst_dadel",  {31'd0, D_AdEL}, 32'd0);
        chk("rst_taken",  {31'd0, D_Taken}, 32'd0);

        reset = 1'b0;
        step();
        chk("rel_fpc",    F_PC, 32'h3004);
        chk("rel_dpc",    D_PC, 32'h3000);
        chk("rel_dvalid", {31'd0, D_valid}, 32'd1);
        chk("rel_fadel",  {31'd0, F_AdEL}, 32'd0);
        step(); step();
        chk("seq_dpc", D_PC, 32'h3008);
        chk("seq_fpc", F_PC, 32'h300C);

        // beq taken, backward offset: 0x3008+4-8 = 0x3004
        set_d(4'd1, 16'hFFFE, 32'd5, 32'd5);
        chk("beq_taken", {31'd0, D_Taken}, 32'd1);
        step();
        chk("beq_fpc", F_PC, 32'h3004);
        chk("beq_slot_dpc", D_PC, 32'h300C);

        // beq not taken
        set_d(4'd1, 16'hFFFE, 32'd5, 32'd6);
        chk("beq_nt", {31'd0, D_Taken}, 32'd0);
        step();
        chk("beq_nt_fpc", F_PC, 32'h3008);
        chk("beq_nt_dpc", D_PC, 32'h3004);

        // bltz on most-negative value: 0x3004+4+0x40 = 0x3048
        set_d(4'd5, 16'h0010, 32'h8000_0000, 32'd0);
        chk("bltz_taken", {31'd0, D_Taken}, 32'd1);
        step();
        chk("bltz_fpc", F_PC, 32'h3048);

        // bgez same operand: not taken
        set_d(4'd6, 16'h0010, 32'h8000_0000, 32'd0);
        chk("bgez_nt", {31'd0, D_Taken}, 32'd0);
        step();
        chk("bgez_fpc", F_PC, 32'h304C);
        chk("bgez_dpc", D_PC, 32'h3048);

        // bgtz at zero: not taken; blez at zero: taken (0x3048+4+4)
        set_d(4'd4, 16'h0001, 32'd0, 32'd0);
        chk("bgtz_zero", {31'd0, D_Taken}, 32'd0);
        set_d(4'd3, 16'h0001, 32'd0, 32'd0);
        chk("blez_zero", {31'd0, D_Taken}, 32'd1);
        // bne equal and unused code 9 never taken
        set_d(4'd2, 16'h0001, 32'd7, 32'd7);
        chk("bne_eq", {31'd0, D_Taken}, 32'd0);
        set_d(4'd9, 16'h0001, 32'd7, 32'd8);
        chk("code9", {31'd0, D_Taken}, 32'd0);
        set_d(4'd3, 16'h0001, 32'd0, 32'd0);
        step();
        chk("blez_fpc", F_PC, 32'h3050);
        chk("blez_dpc", D_PC, 32'h304C);

        // j: {D_PC[31:28], 0xD00, 00} = 0x3400
        D_Addr26 = 26'h0000D00;
        set_d(4'd7, 16'h0000, 32'd0, 32'd0);
        chk("j_taken", {31'd0, D_Taken}, 32'd1);
        step();
        chk("j_fpc", F_PC, 32'h3400);
        chk("j_dpc", D_PC, 32'h3050);

        // jr under stall: nothing moves for three cycles
        Stall = 1'b1;
        set_d(4'd8, 16'h0000, 32'h3100, 32'd0);
        step(); step(); step();
        chk("stall_fpc", F_PC, 32'h3400);
        chk("stall_dpc", D_PC, 32'h3050);
        chk("stall_dvalid", {31'd0, D_valid}, 32'd1);
        Stall = 1'b0;
        step();
        chk("jr_fpc", F_PC, 32'h3100);
        chk("jr_dpc", D_PC, 32'h3400);

        // Redirect beats stall and a taken branch in D
        Req = 1'b1; Req_PC = 32'h4180; Stall = 1'b1;
        set_d(4'd1, 16'h0004, 32'd1, 32'd1);
        step();
        chk("req_fpc", F_PC, 32'h4180);
        chk("req_dvalid", {31'd0, D_valid}, 32'd0);
        chk("req_dpc", D_PC, 32'h0);
        Req = 1'b0;
        #1;
        chk("bubble_taken", {31'd0, D_Taken}, 32'd0);
        Stall = 1'b0;
        set_d(4'd0, 16'h0000, 32'd0, 32'd0);
        step();
        chk("post_req_fpc", F_PC, 32'h4184);
        chk("post_req_dpc", D_PC, 32'h4180);

        // Address-error detection
        set_d(4'd8, 16'h0000, 32'h3002, 32'd0);
        step();
        chk("mis_fpc", F_PC, 32'h3002);
        chk("mis_fadel", {31'd0, F_AdEL}, {31'd0, c_adel});
        chk("mis_dadel0", {31'd0, D_AdEL}, 32'd0);
        set_d(4'd0, 16'h0000, 32'd0, 32'd0);
        step();
        chk("mis_dadel1", {31'd0, D_AdEL}, {31'd0, c_adel});
        chk("mis_fpc2", F_PC, 32'h3006);
        set_d(4'd8, 16'h0000, 32'h7000, 32'd0);
        step();
        chk("hi_fpc", F_PC, 32'h7000);
        chk("hi_fadel", {31'd0, F_AdEL}, {31'd0, c_adel});
        set_d(4'd8, 16'h0000, 32'h6FFC, 32'd0);
        step();
        chk("edge_hi_fadel", {31'd0, F_AdEL}, 32'd0);
        chk("hi_dadel", {31'd0, D_AdEL}, {31'd0, c_adel});
        set_d(4'd8, 16'h0000, 32'h2FFC, 32'd0);
        step();
        chk("lo_fpc", F_PC, 32'h2FFC);
        chk("lo_fadel", {31'd0, F_AdEL}, {31'd0, c_adel});
        chk("edge_hi_dadel", {31'd0, D_AdEL}, 32'd0);

        // Reset overrides a simultaneous redirect
        reset = 1'b1; Req = 1'b1; Req_PC = 32'h5000;
        step();
        chk("rst_req_fpc", F_PC, 32'h3000);
        chk("rst_req_dvalid", {31'd0, D_valid}, 32'd0);
        reset = 1'b0; Req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
